ahb_single_master: RTL and testbench



---
 rtl/ahb_single_master.sv | 214 +++++++++++++++++++++
 tb/tb_ahb_single_master.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_single_master.sv
// AHB-Lite single-transfer bus initiator: converts a CPU req/done handshake into
// arbitrated NONSEQ transfers with lock, slave wait states, two-cycle ERROR and grant timeout.
module ahb_single_master #(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned GRANT_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    output logic              cpu_ready,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [2:0]        cpu_size,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_lock,
    output logic              cpu_done,
    output logic              cpu_err,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              HBUSREQ,
    output logic              HLOCK,
    input  logic              HGRANT,
    output logic [1:0]        HTRANS,
    output logic [ADDR_W-1:0] HADDR,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY,
    input  logic [1:0]        HRESP
);

    localparam int unsigned CNT_W = (GRANT_TIMEOUT < 2) ? 1 : $clog2(GRANT_TIMEOUT + 1);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [2:0] SIZE_WORD    = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ADDR,
        S_DATA,
        S_ERR2
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               lat_write, lat_write_nxt;
    logic               lat_lock, lat_lock_nxt;
    logic [ADDR_W-1:0]  lat_addr, lat_addr_nxt;
    logic [2:0]         lat_size, lat_size_nxt;
    logic [DATA_W-1:0]  lat_wdata, lat_wdata_nxt;

    logic               hbusreq_nxt, hlock_nxt, hwrite_nxt;
    logic [1:0]         htrans_nxt;
    logic [ADDR_W-1:0]  haddr_nxt;
    logic [2:0]         hsize_nxt;
    logic [DATA_W-1:0]  hwdata_nxt;
    logic               cpu_done_nxt, cpu_err_nxt;
    logic [DATA_W-1:0]  cpu_rdata_nxt;

    logic misaligned, grant_ok, timeout_hit, resp_err;

    // Request qualification and bus condition decodes
    always_comb begin
        misaligned  = (cpu_size > 3'd2)
                   || ((cpu_size == 3'd1) && cpu_addr[0])
                   || ((cpu_size == 3'd2) && (cpu_addr[1:0] != 2'b00));
        grant_ok    = HGRANT && HREADY;
        timeout_hit = (GRANT_TIMEOUT != 0) && (cnt == CNT_W'(GRANT_TIMEOUT - 1));
        resp_err    = (HRESP != RESP_OKAY);
    end

    assign cpu_ready = (state == S_IDLE);

    // Next-state decision
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (cpu_req && !misaligned) state_nxt = S_REQ;
            S_REQ: begin
                if (grant_ok)         state_nxt = S_ADDR;
                else if (timeout_hit) state_nxt = S_IDLE;
            end
            S_ADDR: if (HREADY) state_nxt = S_DATA;
            S_DATA: begin
                if (HREADY)        state_nxt = S_IDLE;
                else if (resp_err) state_nxt = S_ERR2;
            end
            S_ERR2: if (HREADY) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next values for the registered bus/CPU outputs, request latch and timeout counter
    always_comb begin
        cnt_nxt       = cnt;
        lat_write_nxt = lat_write;
        lat_lock_nxt  = lat_lock;
        lat_addr_nxt  = lat_addr;
        lat_size_nxt  = lat_size;
        lat_wdata_nxt = lat_wdata;
        hbusreq_nxt   = HBUSREQ;
        hlock_nxt     = HLOCK;
        htrans_nxt    = HTRANS;
        haddr_nxt     = HADDR;
        hwrite_nxt    = HWRITE;
        hsize_nxt     = HSIZE;
        hwdata_nxt    = HWDATA;
        cpu_done_nxt  = 1'b0;
        cpu_err_nxt   = 1'b0;
        cpu_rdata_nxt = cpu_rdata;
        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (cpu_req) begin
                    lat_write_nxt = cpu_write;
                    lat_lock_nxt  = cpu_lock;
                    lat_addr_nxt  = cpu_addr;
                    lat_size_nxt  = cpu_size;
                    lat_wdata_nxt = cpu_wdata;
                    if (misaligned) begin
                        cpu_done_nxt = 1'b1;
                        cpu_err_nxt  = 1'b1;
                    end else begin
                        hbusreq_nxt = 1'b1;
                        hlock_nxt   = cpu_lock;
                    end
                end
            end
            S_REQ: begin
                if (grant_ok) begin
                    hbusreq_nxt = 1'b0;
                    htrans_nxt  = TRANS_NONSEQ;
                    haddr_nxt   = lat_addr;
                    hwrite_nxt  = lat_write;
                    hsize_nxt   = lat_size;
                end else if (timeout_hit) begin
                    hbusreq_nxt  = 1'b0;
                    hlock_nxt    = 1'b0;
                    cpu_done_nxt = 1'b1;
                    cpu_err_nxt  = 1'b1;
                end else if (GRANT_TIMEOUT != 0) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_ADDR: begin
                if (HREADY) begin
                    htrans_nxt = TRANS_IDLE;
                    hlock_nxt  = 1'b0;
                    hwdata_nxt = lat_write ? lat_wdata : '0;
                end
            end
            S_DATA: begin
                if (HREADY) begin
                    cpu_done_nxt = 1'b1;
                    cpu_err_nxt  = resp_err;
                    if (!resp_err && !lat_write) cpu_rdata_nxt = HRDATA;
                end
            end
            S_ERR2: begin
                if (HREADY) begin
                    cpu_done_nxt = 1'b1;
                    cpu_err_nxt  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            lat_write <= 1'b0;
            lat_lock  <= 1'b0;
            lat_addr  <= '0;
            lat_size  <= SIZE_WORD;
            lat_wdata <= '0;
            HBUSREQ   <= 1'b0;
            HLOCK     <= 1'b0;
            HTRANS    <= TRANS_IDLE;
            HADDR     <= '0;
            HWRITE    <= 1'b0;
            HSIZE     <= SIZE_WORD;
            HWDATA    <= '0;
            cpu_done  <= 1'b0;
            cpu_err   <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            lat_write <= lat_write_nxt;
            lat_lock  <= lat_lock_nxt;
            lat_addr  <= lat_addr_nxt;
            lat_size  <= lat_size_nxt;
            lat_wdata <= lat_wdata_nxt;
            HBUSREQ   <= hbusreq_nxt;
            HLOCK     <= hlock_nxt;
            HTRANS    <= htrans_nxt;
            HADDR     <= haddr_nxt;
            HWRITE    <= hwrite_nxt;
            HSIZE     <= hsize_nxt;
            HWDATA    <= hwdata_nxt;
            cpu_done  <= cpu_done_nxt;
            cpu_err   <= cpu_err_nxt;
            cpu_rdata <= cpu_rdata_nxt;
        end
    end

endmodule

// File: tb/tb_ahb_single_master.sv
// Bench for ahb_single_master: directed scenarios plus randomized transfers, with a
// reactive arbiter/slave and expectations derived from transfer-level timing rules.
module tb_ahb_single_master;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_ready, cpu_write, cpu_lock, cpu_done, cpu_err;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [2:0]  cpu_size;
    logic        HBUSREQ, HLOCK, HGRANT, HWRITE, HREADY;
    logic [1:0]  HTRANS, HRESP;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [2:0]  HSIZE;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_rdata = 32'h0;

    localparam logic [106:0] RST_OUTS = {1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 3'b010,
                                         32'h0, 1'b0, 1'b0, 32'h0};

    always #5 clk = ~clk;

    ahb_single_master #(
        .ADDR_W        (32),
        .DATA_W        (32),
        .GRANT_TIMEOUT (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_ready (cpu_ready),
        .cpu_write (cpu_write),
        .cpu_addr  (cpu_addr),
        .cpu_size  (cpu_size),
        .cpu_wdata (cpu_wdata),
        .cpu_lock  (cpu_lock),
        .cpu_done  (cpu_done),
        .cpu_err   (cpu_err),
        .cpu_rdata (cpu_rdata),
        .HBUSREQ   (HBUSREQ),
        .HLOCK     (HLOCK),
        .HGRANT    (HGRANT),
        .HTRANS    (HTRANS),
        .HADDR     (HADDR),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP)
    );

    // Global safety net so the run always ends
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [106:0] outs();
        return {cpu_ready, HBUSREQ, HLOCK, HTRANS, HADDR, HWRITE, HSIZE, HWDATA,
                cpu_done, cpu_err, cpu_rdata};
    endfunction

    // Bus sits idle under default grant; no stray done pulses
    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            cpu_req = 1'b0;
            HGRANT  = 1'b1;
            HREADY  = 1'b1;
            HRESP   = 2'b00;
            @(posedge clk); #1;
            check("idle_bus", {cpu_ready, HBUSREQ, HLOCK, HTRANS, cpu_done},
                  {1'b1, 1'b0, 1'b0, 2'b00, 1'b0});
        end
    endtask

    // One CPU transfer: gdly cycles without a usable grant (>= TMO means timeout),
    // awaits address-phase stalls, dwaits data-phase waits, optional two-cycle ERROR.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, input logic lock, input int gdly,
                        input int awaits, input int dwaits, input bit err,
                        input logic [31:0] rdata, input bit grant_low_only);
        bit          mis, tmo, seen_done, in_data, enter_data, exp_err;
        int          exp_lat, exp_breq, exp_nseq, done_cyc;
        int          breq_cnt, nseq_cnt, gcnt, acnt, dcnt, estage;
        logic        got_err;
        logic [31:0] got_rdata;

        mis = (size > 3'd2) || ((size == 3'd1) && addr[0]) ||
              ((size == 3'd2) && (addr[1:0] != 2'b00));
        tmo = !mis && (gdly >= TMO);
        if (mis) begin
            exp_lat = 1; exp_breq = 0; exp_nseq = 0;
        end else if (tmo) begin
            exp_lat = 1 + TMO; exp_breq = TMO; exp_nseq = 0;
        end else begin
            exp_lat  = 4 + gdly + awaits + dwaits + (err ? 1 : 0);
            exp_breq = gdly + 1;
            exp_nseq = awaits + 1;
        end
        exp_err   = mis || tmo || err;
        seen_done = 1'b0; in_data = 1'b0; done_cyc = -1;
        breq_cnt = 0; nseq_cnt = 0; gcnt = 0; acnt = 0; dcnt = 0; estage = 0;
        got_err = 1'bx; got_rdata = 'x;

        check("ready_idle", cpu_ready, 1'b1);
        cpu_req = 1'b1; cpu_write = wr; cpu_addr = addr; cpu_size = size;
        cpu_wdata = wdata; cpu_lock = lock;
        HGRANT = 1'b1; HREADY = 1'b1; HRESP = 2'b00; HRDATA = $urandom;

        for (int cyc = 1; cyc <= 40 && !seen_done; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1) check("ready_busy", cpu_ready, mis);
            if (cpu_done) begin
                seen_done = 1'b1;
                done_cyc  = cyc;
                got_err   = cpu_err;
                got_rdata = cpu_rdata;
                check("bus_idle_at_done", {HBUSREQ, HTRANS}, 3'b000);
            end else begin
                if (HBUSREQ) begin
                    breq_cnt++;
                    check("hlock_req", HLOCK, lock);
                end
                enter_data = 1'b0;
                // busy-time requests must be ignored
                cpu_req   = 1'($urandom_range(0, 1));
                cpu_write = 1'($urandom_range(0, 1));
                cpu_addr  = $urandom;
                cpu_size  = 3'($urandom_range(0, 7));
                cpu_wdata = $urandom;
                cpu_lock  = 1'($urandom_range(0, 1));
                HGRANT = 1'b1; HREADY = 1'b1; HRESP = 2'b00; HRDATA = $urandom;
                if (HBUSREQ && gcnt < gdly) begin
                    gcnt++;
                    if (grant_low_only || $urandom_range(0, 1) == 0) HGRANT = 1'b0;
                    else HREADY = 1'b0;
                end
                if (HTRANS == 2'b10) begin
                    nseq_cnt++;
                    check("addr_phase", {HADDR, HWRITE, HSIZE, HLOCK}, {addr, wr, size, lock});
                    if (acnt < awaits) begin
                        acnt++;
                        HREADY = 1'b0;
                    end else begin
                        enter_data = 1'b1;
                    end
                end else if (in_data) begin
                    check("data_phase", {HTRANS, HLOCK, HWDATA},
                          {2'b00, 1'b0, (wr ? wdata : 32'h0)});
                    if (dcnt < dwaits) begin
                        dcnt++;
                        HREADY = 1'b0;
                    end else if (!err) begin
                        HRDATA = rdata;
                    end else if (estage == 0) begin
                        estage = 1;
                        HREADY = 1'b0;
                        HRESP  = 2'b01;
                    end else begin
                        HRESP = 2'b01;
                    end
                end
                if (enter_data) in_data = 1'b1;
            end
        end

        if (!exp_err && !wr) exp_rdata = rdata;
        check("latency", done_cyc, exp_lat);
        check("cpu_err", got_err, exp_err);
        check("cpu_rdata", got_rdata, exp_rdata);
        check("busreq_cycles", breq_cnt, exp_breq);
        check("nonseq_cycles", nseq_cnt, exp_nseq);
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  sz;
        int          g;

        rst = 1'b1; cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_size = 3'd2;
        cpu_wdata = '0; cpu_lock = 1'b0; HGRANT = 1'b1; HREADY = 1'b1; HRESP = 2'b00;
        HRDATA = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset_values", outs(), RST_OUTS);
        rst = 1'b0;

        idle_gap(2);
        // zero-wait read
        xfer(1'b0, 32'h0000_0010, 3'd2, 32'h0, 1'b0, 0, 0, 0, 1'b0, 32'hDEAD_BEEF, 1'b0);
        idle_gap(1);
        // write, grant 3 cycles late, 2 slave waits
        xfer(1'b1, 32'h0000_0020, 3'd2, 32'h1234_5678, 1'b0, 3, 0, 2, 1'b0, 32'h0, 1'b1);
        // two-cycle ERROR on a read, back-to-back with the previous done
        xfer(1'b0, 32'h0000_0030, 3'd2, 32'h0, 1'b0, 0, 0, 0, 1'b1, 32'h5555_AAAA, 1'b0);
        // misaligned word read
        xfer(1'b0, 32'h0000_0006, 3'd2, 32'h0, 1'b0, 0, 0, 0, 1'b0, 32'h0, 1'b0);
        // grant never arrives
        xfer(1'b0, 32'h0000_0044, 3'd2, 32'h0, 1'b1, 100, 0, 0, 1'b0, 32'h0, 1'b1);
        idle_gap(1);
        // locked halfword write with address-phase stalls
        xfer(1'b1, 32'h0000_0102, 3'd1, 32'h0000_ABCD, 1'b1, 1, 2, 1, 1'b0, 32'h0, 1'b0);
        // size 011 rejected
        xfer(1'b0, 32'h0000_0200, 3'd3, 32'h0, 1'b0, 0, 0, 0, 1'b0, 32'h0, 1'b0);

        // locked read interrupted by reset during the address phase
        cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h40; cpu_size = 3'd2;
        cpu_wdata = 32'h0; cpu_lock = 1'b1; HGRANT = 1'b1; HREADY = 1'b1; HRESP = 2'b00;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        check("lock_req", {HBUSREQ, HLOCK}, 2'b11);
        @(posedge clk); #1;
        check("lock_addr", {HTRANS, HLOCK}, {2'b10, 1'b1});
        rst = 1'b1;
        @(posedge clk); #1;
        check("reset_mid_transfer", outs(), RST_OUTS);
        rst = 1'b0;
        @(posedge clk); #1;
        check("no_done_after_reset", {cpu_done, HTRANS, HBUSREQ}, 4'b0000);
        exp_rdata = 32'h0;
        xfer(1'b0, 32'h0000_0048, 3'd2, 32'h0, 1'b0, 0, 0, 0, 1'b0, 32'hCAFE_F00D, 1'b0);

        // randomized transfers
        for (int t = 0; t < 40; t++) begin
            sz = 3'($urandom_range(0, 4));
            if (sz == 3'd4) sz = 3'd2;
            a = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) g = TMO;
            else g = $urandom_range(0, TMO - 1);
            xfer(1'($urandom_range(0, 1)), a, sz, $urandom, 1'($urandom_range(0, 1)), g,
                 $urandom_range(0, 2), $urandom_range(0, 3), ($urandom_range(0, 4) == 0),
                 $urandom, 1'b0);
            idle_gap($urandom_range(0, 2));
        end

        cpu_req = 1'b0;
        idle_gap(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
